// File: rtl/spi_host_lite_pkg.sv
// Shared types and constants for the lightweight SPI host.
package spi_host_lite_pkg;

  localparam int BitsPerByte = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StByteEnd,
    StWait,
    StHold,
    StGap
  } spi_host_state_e;

endpackage

// File: rtl/spi_host_lite_tick.sv
// Half-period timer: counts 0..limit and pulses tick_o on the last count, then wraps.
module spi_host_lite_tick #(
  parameter int DivW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [DivW-1:0] limit_i,
  input  logic            clear_i,
  input  logic            en_i,
  output logic            tick_o
);

  logic [DivW-1:0] limit_q;
  logic [DivW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && !clear_i && (cnt_q == limit_q);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + DivW'(1);
    end
  end

  // The limit is H-1, so a full-scale limit gives H = 2^DivW without overflow.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      limit_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (load_i) begin
        limit_q <= limit_i;
      end
    end
  end

endmodule

// File: rtl/spi_host_lite.sv
// Mode-0, MSB-first SPI master turning a valid/ready byte stream into CS-framed bursts.
module spi_host_lite
  import spi_host_lite_pkg::*;
#(
  parameter int DivW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [DivW-1:0] cfg_clkdiv_i,
  input  logic            tx_valid_i,
  output logic            tx_ready_o,
  input  logic [7:0]      tx_data_i,
  input  logic            tx_last_i,
  output logic            rx_valid_o,
  output logic [7:0]      rx_data_o,
  output logic            busy_o,
  output logic            spi_sclk_o,
  output logic            spi_cs_o,
  output logic            spi_sdo_o,
  input  logic            spi_sdi_i
);

  localparam int EdgeW = $clog2(2 * BitsPerByte);
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * BitsPerByte - 1);

  spi_host_state_e state_q, state_d;

  logic                   accept;
  logic                   tick;
  logic                   tickEn;
  logic                   lastEdge;
  logic                   last_q;
  logic                   sclk_q;
  logic                   cs_q;
  logic                   sdo_q;
  logic [EdgeW-1:0]       edgeCnt_q;
  logic [BitsPerByte-1:0] txShift_q;
  logic [BitsPerByte-1:0] rxShift_q;
  logic [BitsPerByte-1:0] rxData_q;

  assign tickEn     = state_q inside {StSetup, StShift, StHold, StGap};
  assign lastEdge   = (edgeCnt_q == LastEdge);
  assign tx_ready_o = rst_ni && ((state_q == StIdle) || (state_q == StWait) ||
                                 ((state_q == StByteEnd) && !last_q));
  assign accept     = tx_valid_i && tx_ready_o;

  assign rx_valid_o = (state_q == StByteEnd);
  assign rx_data_o  = rxData_q;
  assign busy_o     = (state_q != StIdle);
  assign spi_sclk_o = sclk_q;
  assign spi_cs_o   = cs_q;
  assign spi_sdo_o  = sdo_q;

  // The divider is captured only at the start of a frame.
  spi_host_lite_tick #(
    .DivW(DivW)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (accept && (state_q == StIdle)),
    .limit_i(cfg_clkdiv_i),
    .clear_i(!tickEn),
    .en_i   (tickEn),
    .tick_o (tick)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = StSetup;
      StSetup:   if (tick) state_d = StShift;
      StShift:   if (tick && lastEdge) state_d = StByteEnd;
      StByteEnd: begin
        if (last_q) begin
          state_d = StHold;
        end else if (accept) begin
          state_d = StSetup;
        end else begin
          state_d = StWait;
        end
      end
      StWait:    if (accept) state_d = StSetup;
      StHold:    if (tick) state_d = StGap;
      StGap:     if (tick) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Pins are registered from the next state so CS never glitches on decode.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      sdo_q     <= 1'b0;
      last_q    <= 1'b0;
      edgeCnt_q <= '0;
      txShift_q <= '0;
      rxShift_q <= '0;
      rxData_q  <= '0;
    end else begin
      cs_q <= (state_d == StIdle) || (state_d == StGap);
      if (accept) begin
        sdo_q     <= tx_data_i[BitsPerByte-1];
        txShift_q <= {tx_data_i[BitsPerByte-2:0], 1'b0};
        last_q    <= tx_last_i;
        edgeCnt_q <= '0;
      end
      if ((state_q == StShift) && tick) begin
        sclk_q    <= ~sclk_q;
        edgeCnt_q <= edgeCnt_q + EdgeW'(1);
        if (!sclk_q) begin
          rxShift_q <= {rxShift_q[BitsPerByte-2:0], spi_sdi_i};
        end else if (!lastEdge) begin
          sdo_q     <= txShift_q[BitsPerByte-1];
          txShift_q <= {txShift_q[BitsPerByte-2:0], 1'b0};
        end
        if (lastEdge) begin
          rxData_q <= rxShift_q;
        end
      end
      if ((state_q == StGap) && tick) begin
        sdo_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_host_lite.sv
// Directed bench for spi_host_lite: single-byte vector table plus multi-byte, stall and reset sequences.
module tb_spi_host_lite;

  localparam int DivW = 8;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [7:0] cfgDiv = '0;
  logic       txValid = 1'b0;
  logic [7:0] txData = '0;
  logic       txLast = 1'b0;
  logic       txReady, rxValid, busy, spiSclk, spiCs, spiSdo, spiSdi;
  logic [7:0] rxData;

  int errCnt = 0;
  int chkCnt = 0;

  bit         loopMode = 1'b1;
  logic [7:0] slaveB0 = '0;
  logic [7:0] slaveB1 = '0;
  int         fallBase = 0;
  int         fallCnt = 0;

  int         cycle = 0;
  int         csLowCnt = 0;
  int         csRiseCnt = 0;
  int         csFallCycle = 0;
  int         riseCnt = 0;
  int         run = 0;
  bit         fallSeen = 1'b0;
  bit         prevCs = 1'b1;
  bit         prevSclk = 1'b0;
  logic [7:0] rxQ[$];
  int         rxCyc[$];
  bit         mosiQ[$];
  int         highRuns[$];
  int         lowRuns[$];

  typedef struct {
    logic [7:0] div;
    logic [7:0] midDiv;
    logic [7:0] data;
    bit         loop;
    logic [7:0] slave;
    logic [7:0] expRx;
    int         expCsLow;
    int         expRxDelay;
    int         expRun;
  } vec_t;

  vec_t vecs[7];

  spi_host_lite #(.DivW(DivW)) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .cfg_clkdiv_i(cfgDiv),
    .tx_valid_i  (txValid),
    .tx_ready_o  (txReady),
    .tx_data_i   (txData),
    .tx_last_i   (txLast),
    .rx_valid_o  (rxValid),
    .rx_data_o   (rxData),
    .busy_o      (busy),
    .spi_sclk_o  (spiSclk),
    .spi_cs_o    (spiCs),
    .spi_sdo_o   (spiSdo),
    .spi_sdi_i   (spiSdi)
  );

  always #5 clk = ~clk;

  // Device model: presents MSB first and advances one bit per SCLK falling edge.
  function automatic logic slaveBit(input int n, input logic [7:0] b0, input logic [7:0] b1);
    if (n < 0) return 1'b0;
    if (n < 8) return b0[7-n];
    if (n < 16) return b1[15-n];
    return 1'b0;
  endfunction

  assign spiSdi = loopMode ? spiSdo : slaveBit(fallCnt - fallBase, slaveB0, slaveB1);

  always @(negedge spiSclk) fallCnt++;

  // Pin monitor sampled on the inactive clock edge.
  always @(negedge clk) begin
    cycle++;
    if (spiCs === 1'b0) csLowCnt++;
    if (prevCs && spiCs === 1'b0) csFallCycle = cycle;
    if (!prevCs && spiCs === 1'b1) csRiseCnt++;
    if (rxValid === 1'b1) begin
      rxQ.push_back(rxData);
      rxCyc.push_back(cycle);
    end
    if (spiSclk === 1'b1 && !prevSclk) begin
      riseCnt++;
      mosiQ.push_back(spiSdo);
      if (fallSeen) lowRuns.push_back(run);
      run = 1;
    end else if (spiSclk === 1'b0 && prevSclk) begin
      highRuns.push_back(run);
      fallSeen = 1'b1;
      run = 1;
    end else begin
      run++;
    end
    if (spiCs !== 1'b0) fallSeen = 1'b0;
    prevCs   = (spiCs !== 1'b0);
    prevSclk = (spiSclk === 1'b1);
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    chkCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    txValid = 1'b1;
    txData  = d;
    txLast  = l;
    while (txReady !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("acceptTimeout", int'(n >= 20000), 0);
    @(posedge clk);
    #1;
    txValid = 1'b0;
    txLast  = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 20000);
    checkOutput("idleTimeout", int'(busy !== 1'b0), 0);
    #1;
  endtask

  function automatic int mosiByte(input int off);
    logic [7:0] b = '0;
    if (mosiQ.size() < off + 8) return -1;
    for (int i = 0; i < 8; i++) b = {b[6:0], mosiQ[off+i]};
    return int'(b);
  endfunction

  function automatic int rxAt(input int idx);
    if (rxQ.size() <= idx) return -1;
    return int'(rxQ[idx]);
  endfunction

  initial begin
    int sRise, sRx, sMosi, sCsLow, sHigh, sLow, sCsRise, bad, n, r;
    bit p;

    vecs[0] = '{8'd0,   8'd0,   8'hA5, 1'b1, 8'h00, 8'hA5, 19,   17,   1};
    vecs[1] = '{8'd3,   8'd3,   8'h3B, 1'b1, 8'h00, 8'h3B, 73,   68,   4};
    vecs[2] = '{8'd1,   8'd1,   8'h80, 1'b1, 8'h00, 8'h80, 37,   34,   2};
    vecs[3] = '{8'd2,   8'd2,   8'h00, 1'b0, 8'h96, 8'h96, 55,   51,   3};
    vecs[4] = '{8'd1,   8'd5,   8'hFF, 1'b1, 8'h00, 8'hFF, 37,   34,   2};
    vecs[5] = '{8'd5,   8'd5,   8'h01, 1'b1, 8'h00, 8'h01, 109,  102,  6};
    vecs[6] = '{8'd255, 8'd255, 8'h6D, 1'b1, 8'h00, 8'h6D, 4609, 4352, 256};

    // Reset values while reset is held, then IDLE readiness after release.
    repeat (3) @(negedge clk);
    checkOutput("rstCs", int'(spiCs), 1);
    checkOutput("rstSclk", int'(spiSclk), 0);
    checkOutput("rstSdo", int'(spiSdo), 0);
    checkOutput("rstReady", int'(txReady), 0);
    checkOutput("rstRxValid", int'(rxValid), 0);
    checkOutput("rstRxData", int'(rxData), 0);
    checkOutput("rstBusy", int'(busy), 0);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("idleReady", int'(txReady), 1);
    checkOutput("idleBusy", int'(busy), 0);

    for (int v = 0; v < 7; v++) begin
      cfgDiv   = vecs[v].div;
      loopMode = vecs[v].loop;
      slaveB0  = vecs[v].slave;
      fallBase = fallCnt;
      sRise = riseCnt; sRx = rxQ.size(); sMosi = mosiQ.size();
      sCsLow = csLowCnt; sHigh = highRuns.size(); sLow = lowRuns.size();
      applyStimulus(vecs[v].data, 1'b1);
      cfgDiv = vecs[v].midDiv;
      waitIdle();
      $display("[TB] vector %0d div=%0d data=%02h", v, vecs[v].div, vecs[v].data);
      checkOutput("rxCount", rxQ.size() - sRx, 1);
      checkOutput("rxData", rxAt(sRx), int'(vecs[v].expRx));
      checkOutput("sclkRises", riseCnt - sRise, 8);
      checkOutput("mosiBits", mosiByte(sMosi), int'(vecs[v].data));
      checkOutput("csLowCycles", csLowCnt - sCsLow, vecs[v].expCsLow);
      checkOutput("rxDelay", (rxCyc.size() > sRx) ? rxCyc[sRx] - csFallCycle : -1,
                  vecs[v].expRxDelay);
      bad = 0;
      for (int i = sHigh; i < highRuns.size(); i++) if (highRuns[i] != vecs[v].expRun) bad++;
      checkOutput("highRunBad", bad, 0);
      checkOutput("highRunCount", highRuns.size() - sHigh, 8);
      bad = 0;
      for (int i = sLow; i < lowRuns.size(); i++) if (lowRuns[i] != vecs[v].expRun) bad++;
      checkOutput("lowRunBad", bad, 0);
      checkOutput("lowRunCount", lowRuns.size() - sLow, 7);
    end

    // Two-byte burst against a device returning 0x5A then 0x0F.
    cfgDiv = 8'd1; loopMode = 1'b0; slaveB0 = 8'h5A; slaveB1 = 8'h0F;
    fallBase = fallCnt;
    sRise = riseCnt; sRx = rxQ.size(); sMosi = mosiQ.size(); sCsRise = csRiseCnt;
    applyStimulus(8'h3C, 1'b0);
    applyStimulus(8'hC3, 1'b1);
    waitIdle();
    checkOutput("burstCsRises", csRiseCnt - sCsRise, 1);
    checkOutput("burstRxCount", rxQ.size() - sRx, 2);
    checkOutput("burstRx0", rxAt(sRx), 8'h5A);
    checkOutput("burstRx1", rxAt(sRx + 1), 8'h0F);
    checkOutput("burstMosi0", mosiByte(sMosi), 8'h3C);
    checkOutput("burstMosi1", mosiByte(sMosi + 8), 8'hC3);
    checkOutput("burstRises", riseCnt - sRise, 16);

    // Stall between bytes: the link must idle quietly with CS held low.
    cfgDiv = 8'd0; loopMode = 1'b1;
    sRx = rxQ.size(); sMosi = mosiQ.size();
    applyStimulus(8'h11, 1'b0);
    n = 0;
    while (rxValid !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stallRxTimeout", int'(n >= 1000), 0);
    sRise = riseCnt;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (spiCs !== 1'b0 || spiSclk !== 1'b0) bad++;
    end
    checkOutput("stallPins", bad, 0);
    checkOutput("stallReady", int'(txReady), 1);
    #1;
    checkOutput("stallRises", riseCnt - sRise, 0);
    applyStimulus(8'h22, 1'b1);
    waitIdle();
    checkOutput("stallRx0", rxAt(sRx), 8'h11);
    checkOutput("stallRx1", rxAt(sRx + 1), 8'h22);
    checkOutput("stallMosi1", mosiByte(sMosi + 8), 8'h22);

    // One-cycle reset after the fifth rising SCLK edge.
    cfgDiv = 8'd1; loopMode = 1'b1;
    sRx = rxQ.size();
    applyStimulus(8'h96, 1'b1);
    r = 0; p = 1'b0; n = 0;
    while (r < 5 && n < 1000) begin
      @(negedge clk);
      if (spiSclk === 1'b1 && !p) r++;
      p = (spiSclk === 1'b1);
      n++;
    end
    checkOutput("resetRiseTimeout", int'(n >= 1000), 0);
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("midRstCs", int'(spiCs), 1);
    checkOutput("midRstSclk", int'(spiSclk), 0);
    checkOutput("midRstReady", int'(txReady), 0);
    checkOutput("midRstBusy", int'(busy), 0);
    checkOutput("midRstRxValid", int'(rxValid), 0);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("postRstReady", int'(txReady), 1);
    repeat (40) @(negedge clk);
    #1;
    checkOutput("noPartialRx", rxQ.size() - sRx, 0);
    sRise = riseCnt; sMosi = mosiQ.size();
    applyStimulus(8'h7E, 1'b1);
    waitIdle();
    checkOutput("postRstRx", rxAt(sRx), 8'h7E);
    checkOutput("postRstRises", riseCnt - sRise, 8);
    checkOutput("postRstMosi", mosiByte(sMosi), 8'h7E);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
